ctrl_issue_unit: RTL and testbench
==================================

CTRL_ISSUE_UNIT -- requirements
Module: ctrl_issue_unit

Interface
REQ-001 Parameter CMD_W, default 4, width of exec_cmd.
REQ-002 Parameter MEM_TIMEOUT, default 15, max MEM_WAIT cycles before mem_err is raised; legal range 1..255.
REQ-003 Parameter COND_EN, default 1, enables ARM condition-code gating; 0 treats every cond as AL.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 valid_in  in  1  decoded instruction fields valid this cycle.
REQ-008 mode  in  2  instruction class: 00 arithmetic, 01 memory, 10 branch, 11 co-processor.
REQ-009 opcode  in  4  data-processing opcode.
REQ-010 s  in  1  set-flags bit (arithmetic) / load bit (memory).
REQ-011 imm_in  in  1  immediate-operand bit.
REQ-012 cond  in  4  ARM condition field.
REQ-013 status  in  4  current flags {N,Z,C,V}.
REQ-014 stall  in  1  hold current outputs, accept nothing.
REQ-015 flush  in  1  squash issued and pending instruction.
REQ-016 mem_ready  in  1  data memory completed the outstanding access.
REQ-017 exec_cmd  out  CMD_W; mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm, valid_out  out  1 each; all registered.
REQ-018 busy  out  1  memory access outstanding; upstream holds its instruction.
REQ-019 mem_err  out  1  sticky; MEM_TIMEOUT expired.

Function
REQ-020 Decode: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; exec_cmd zero-extended to CMD_W.
REQ-021 Arithmetic: wb_en=1 except CMP/TST; status_w_en = s, forced 1 for CMP/TST; unlisted opcodes issue with all enables 0.
REQ-022 Memory: s=1 -> LDR (mem_r_en=1, wb_en=1, exec_cmd=0010); s=0 -> STR (mem_w_en=1, exec_cmd=0010); status_w_en=0.
REQ-023 Branch: branch_taken=1, all other enables 0; co-processor: all enables 0, valid_out=1.
REQ-024 Condition: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL evaluated on status; cond=1111 treated as never. A failing cond issues valid_out=1 with every enable (including branch_taken) 0.
REQ-025 Latency: one cycle, fields sampled on edge N with valid_in=1 appear on outputs at edge N+1.
REQ-026 FSM states: IDLE, MEM_WAIT. IDLE + accepted memory op with passing cond -> MEM_WAIT; MEM_WAIT + mem_ready -> IDLE.
REQ-027 In MEM_WAIT: busy=1, outputs hold, valid_in ignored; counter increments each cycle; the cycle mem_ready arrives, mem_*_en drop to 0 on the next edge.
REQ-028 Counter reaching MEM_TIMEOUT without mem_ready: set mem_err, clear outputs, return to IDLE.
REQ-029 stall=1: all outputs and state hold; MEM_WAIT counter still counts and mem_ready still honoured.
REQ-030 flush=1: next edge clears every output, counter and state to IDLE; mem_err unaffected.
REQ-031 Priority: rst > flush > mem_ready/timeout > stall > new issue.
REQ-032 valid_in=0 in IDLE without stall: next edge outputs all 0.

Reset
REQ-033 rst=1 on an edge: state IDLE, counter 0, every output 0 including mem_err and busy, regardless of MEM_WAIT or stall.

Structure
REQ-034 Shared package holds mode, opcode, ALU-command and condition-code constants and the FSM state encoding.
REQ-035 One sub-module cond_check (cond, status -> pass), combinational, reusable by the branch unit.

Verification
REQ-036 ADDS r (mode 00, opcode 0100, s=1, cond AL) -> next cycle exec_cmd=0010, wb_en=1, status_w_en=1, valid_out=1.
REQ-037 BEQ with status Z=0 -> valid_out=1, branch_taken=0; with Z=1 -> branch_taken=1.
REQ-038 LDR, mem_ready asserted 3 cycles later -> busy=1 for 3 cycles, mem_r_en held, IDLE afterwards, mem_err=0.
REQ-039 STR, MEM_TIMEOUT=4, no mem_ready -> mem_err=1 after 4 wait cycles, outputs 0, state IDLE.
REQ-040 MOV with stall and flush both 1 the same cycle -> all outputs 0 next edge; rst during MEM_WAIT -> all outputs 0 next edge.

Source files
------------

// File: rtl/ctrl_issue_unit_pkg.sv
// ctrl_issue_unit_pkg: shared encodings for the issue unit and its condition checker.
package ctrl_issue_unit_pkg;
  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_MEM   = 2'b01;
  localparam logic [1:0] MODE_BR    = 2'b10;
  localparam logic [1:0] MODE_COP   = 2'b11;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  typedef enum logic {ST_IDLE, ST_MEM_WAIT} state_e;
  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       status_w;
    logic       branch;
    logic       imm;
    logic       valid;
  } issue_t;
  function automatic logic [3:0] alu_cmd(input logic [3:0] op);
    case (op)
      OP_MOV:  return CMD_MOV;
      OP_MVN:  return CMD_MVN;
      OP_ADD:  return CMD_ADD;
      OP_ADC:  return CMD_ADC;
      OP_SUB:  return CMD_SUB;
      OP_SBC:  return CMD_SBC;
      OP_AND:  return CMD_AND;
      OP_ORR:  return CMD_ORR;
      OP_EOR:  return CMD_EOR;
      OP_CMP:  return CMD_SUB;
      OP_TST:  return CMD_AND;
      default: return CMD_NOP;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_issue_unit_cond_check.sv
// cond_check: combinational ARM condition-code evaluation against {N,Z,C,V}.
module cond_check
  import ctrl_issue_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = status;
  always_comb begin
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_issue_unit.sv
// ctrl_issue_unit: decodes instruction fields into registered execute controls and tracks outstanding memory accesses.
module ctrl_issue_unit
  import ctrl_issue_unit_pkg::*;
#(
  parameter int CMD_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int COND_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s,
  input  logic             imm_in,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [CMD_W-1:0] exec_cmd,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic             status_w_en,
  output logic             branch_taken,
  output logic             imm,
  output logic             valid_out,
  output logic             busy,
  output logic             mem_err
);
  state_e     state_q, state_d;
  issue_t     out_q, out_d, dec;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       cond_pass, pass, tmo;
  cond_check u_cond (.cond(cond), .status(status), .pass(cond_pass));
  assign pass = (COND_EN == 0) || cond_pass;
  assign tmo  = cnt_q + 8'd1 == 8'(MEM_TIMEOUT);
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.imm   = imm_in;
    case (mode)
      MODE_ARITH: begin
        dec.cmd = alu_cmd(opcode);
        if (dec.cmd != CMD_NOP) begin
          dec.wb       = !(opcode == OP_CMP || opcode == OP_TST);
          dec.status_w = s || !dec.wb;
        end
      end
      MODE_MEM: begin
        dec.cmd   = CMD_ADD;
        dec.mem_r = s;
        dec.mem_w = !s;
        dec.wb    = s;
      end
      MODE_BR: dec.branch = 1'b1;
      default: ;
    endcase
    // A failed condition still issues a bubble marked valid, with nothing enabled.
    if (!pass) {dec.mem_r, dec.mem_w, dec.wb, dec.status_w, dec.branch} = '0;
  end
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (flush) begin
      state_d = ST_IDLE;
      out_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_MEM_WAIT) begin
      cnt_d = cnt_q + 8'd1;
      if (mem_ready) begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        out_d.mem_r = 1'b0;
        out_d.mem_w = 1'b0;
      end else if (tmo) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        out_d   = '0;
        err_d   = 1'b1;
      end
    end else if (!stall) begin
      out_d   = valid_in ? dec : '0;
      state_d = (valid_in && mode == MODE_MEM && pass) ? ST_MEM_WAIT : ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign exec_cmd     = CMD_W'(out_q.cmd);
  assign mem_r_en     = out_q.mem_r;
  assign mem_w_en     = out_q.mem_w;
  assign wb_en        = out_q.wb;
  assign status_w_en  = out_q.status_w;
  assign branch_taken = out_q.branch;
  assign imm          = out_q.imm;
  assign valid_out    = out_q.valid;
  assign busy         = state_q == ST_MEM_WAIT;
  assign mem_err      = err_q;
endmodule

// File: tb/tb_ctrl_issue_unit.sv
// tb_ctrl_issue_unit: directed stimulus with a queue-based scoreboard checked once per clock.
module tb_ctrl_issue_unit;
  logic       clk = 1'b0;
  logic       rst, valid_in, s, imm_in, stall, flush, mem_ready;
  logic [1:0] mode;
  logic [3:0] opcode, cond, status, exec_cmd;
  logic       mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm, valid_out, busy, mem_err;
  logic [12:0] act;
  logic [12:0] exp_q[$];
  string       name_q[$];
  int checks = 0;
  int failures = 0;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [12:0] ZERO = 13'd0;
  localparam logic [12:0] ERR = 13'd1;

  always #5 clk = ~clk;

  ctrl_issue_unit #(.CMD_W(4), .MEM_TIMEOUT(4), .COND_EN(1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mode(mode), .opcode(opcode), .s(s),
    .imm_in(imm_in), .cond(cond), .status(status), .stall(stall), .flush(flush),
    .mem_ready(mem_ready), .exec_cmd(exec_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en(wb_en), .status_w_en(status_w_en), .branch_taken(branch_taken), .imm(imm),
    .valid_out(valid_out), .busy(busy), .mem_err(mem_err)
  );

  assign act = {exec_cmd, mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm, valid_out, busy, mem_err};

  function automatic logic [12:0] ex(input logic [3:0] c, input logic r, w, wb, sw, br, im, v, bz, er);
    return {c, r, w, wb, sw, br, im, v, bz, er};
  endfunction

  task automatic ins(input logic vi, input logic [1:0] md, input logic [3:0] op, input logic sb,
                     input logic im, input logic [3:0] cd);
    valid_in = vi; mode = md; opcode = op; s = sb; imm_in = im; cond = cd;
  endtask

  task automatic t(input string nm, input logic [12:0] e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        string nm;
        logic [12:0] e;
        nm = name_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %b expected %b (cmd,r,w,wb,sw,br,imm,v,busy,err)", nm, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_ready = 1'b0; status = 4'b0000;
    ins(1, 2'b00, 4'b0100, 1, 0, AL);
    @(negedge clk);
    t("reset0", ZERO);
    t("reset1", ZERO);
    rst = 1'b0;
    ins(1, 2'b00, 4'b0100, 1, 0, AL); t("adds", ex(2, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    ins(0, 2'b00, 4'b0100, 1, 0, AL); t("idle", ZERO);
    ins(1, 2'b00, 4'b1010, 0, 1, AL); t("cmp", ex(4, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    ins(1, 2'b00, 4'b1101, 0, 0, AL); t("mov", ex(1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    ins(1, 2'b00, 4'b1111, 1, 1, AL); t("mvns", ex(9, 0, 0, 1, 1, 0, 1, 1, 0, 0));
    ins(1, 2'b00, 4'b1000, 0, 0, AL); t("tst", ex(6, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    ins(1, 2'b00, 4'b0001, 0, 0, AL); t("eor", ex(8, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    ins(1, 2'b00, 4'b0011, 1, 0, AL); t("unlisted", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    status = 4'b0000;
    ins(1, 2'b10, 4'b0000, 0, 0, 4'b0000); t("beq_nt", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    status = 4'b0100;
    t("beq_t", ex(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    ins(1, 2'b00, 4'b0100, 1, 0, 4'b1111); t("cond_nv", ex(2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    status = 4'b1000;
    ins(1, 2'b00, 4'b0100, 0, 0, 4'b1100); t("gt_fail", ex(2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    status = 4'b1001;
    ins(1, 2'b00, 4'b0010, 0, 0, 4'b1010); t("ge_pass", ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    ins(1, 2'b11, 4'b0100, 1, 0, AL); t("cop", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    ins(1, 2'b00, 4'b0100, 1, 0, AL); t("adds2", ex(2, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    stall = 1'b1;
    ins(1, 2'b00, 4'b1101, 0, 1, AL); t("stall_hold", ex(2, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    stall = 1'b0;
    ins(0, 2'b00, 4'b0000, 0, 0, AL); t("idle2", ZERO);
    ins(1, 2'b01, 4'b0000, 1, 0, AL); t("ldr_issue", ex(2, 1, 0, 1, 0, 0, 0, 1, 1, 0));
    ins(1, 2'b00, 4'b1101, 0, 1, AL); t("ldr_wait1", ex(2, 1, 0, 1, 0, 0, 0, 1, 1, 0));
    stall = 1'b1;
    t("ldr_wait2", ex(2, 1, 0, 1, 0, 0, 0, 1, 1, 0));
    mem_ready = 1'b1;
    t("ldr_done", ex(2, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    mem_ready = 1'b0; stall = 1'b0;
    ins(0, 2'b00, 4'b0000, 0, 0, AL); t("ldr_idle", ZERO);
    ins(1, 2'b01, 4'b0000, 0, 1, AL); t("str_issue", ex(2, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    ins(0, 2'b00, 4'b0000, 0, 0, AL); t("str_wait1", ex(2, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    stall = 1'b1;
    t("str_wait2", ex(2, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    stall = 1'b0;
    t("str_wait3", ex(2, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    t("str_timeout", ERR);
    t("err_sticky", ERR);
    ins(1, 2'b01, 4'b0000, 1, 0, AL); t("ldr2_issue", ex(2, 1, 0, 1, 0, 0, 0, 1, 1, 1));
    flush = 1'b1;
    t("flush_wait", ERR);
    flush = 1'b0;
    ins(1, 2'b00, 4'b0100, 0, 0, AL); t("add_pre", ex(2, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    stall = 1'b1; flush = 1'b1;
    ins(1, 2'b00, 4'b1101, 0, 0, AL); t("stall_flush", ERR);
    stall = 1'b0; flush = 1'b0;
    ins(1, 2'b01, 4'b0000, 1, 0, AL); t("ldr3_issue", ex(2, 1, 0, 1, 0, 0, 0, 1, 1, 1));
    rst = 1'b1;
    t("rst_wait", ZERO);
    rst = 1'b0;
    status = 4'b0100;
    ins(1, 2'b01, 4'b0000, 1, 0, 4'b0001); t("ldr_nopass", ex(2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    ins(1, 2'b00, 4'b0100, 0, 0, AL); t("after_fail", ex(2, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    ins(0, 2'b00, 4'b0000, 0, 0, AL); t("final_idle", ZERO);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
